// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   N-channel front end for a single RAM transaction port. Requesters
//   present a held ch_txe request with strobes, address and write data; one
//   winner is granted (round-robin or fixed priority) and its transaction is
//   driven toward the RAM with the txe/txs handshake. Each grant ends with
//   exactly one ch_txs (RAM answered) or ch_err (timeout) pulse.
//
// Ports
//   clk, rst              clock (posedge) and asynchronous active-high reset
//   ch_txe/ch_re/ch_we    per-channel request, read strobe, write strobe
//   ch_addr, ch_wd        packed per-channel address / write data
//   ch_txs, ch_err        one-cycle completion / timeout pulse to the grantee
//   ch_out                read data of the last successful transaction
//   ram_txe/re/we         transaction enable and strobes toward the RAM
//   ram_addr, ram_wd      address and write data toward the RAM
//   ram_txs, ram_out      RAM success pulse and read data (valid with txs)
module ram_port_arbiter #(
  parameter int unsigned CH      = 2,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RR      = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH-1:0]        ch_txe,
  input  logic [CH-1:0]        ch_re,
  input  logic [CH-1:0]        ch_we,
  input  logic [CH*ADDR_W-1:0] ch_addr,
  input  logic [CH*DATA_W-1:0] ch_wd,
  output logic [CH-1:0]        ch_txs,
  output logic [CH-1:0]        ch_err,
  output logic [DATA_W-1:0]    ch_out,
  output logic                 ram_txe,
  output logic                 ram_re,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wd,
  input  logic                 ram_txs,
  input  logic [DATA_W-1:0]    ram_out
);

  localparam int unsigned IDX_W = (CH > 1) ? $clog2(CH) : 1;
  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant;
  logic [CNT_W-1:0]   cnt;

  logic               any_req;
  logic [IDX_W-1:0]   win;
  logic               sel_re, sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wd;
  logic               grant_txe;
  logic               timeout_hit;
  logic [IDX_W-1:0]   ptr_next;
  int                 j;

  // Winner selection. Scanning from the far end downward lets the candidate
  // closest to the search start overwrite the others, giving "first set bit
  // at or above ptr" (RR) or "lowest index" (fixed) without a priority chain.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    any_req   = |ch_txe;
    win       = '0;
    j         = 0;
    sel_re    = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wd    = '0;
    grant_txe = 1'b0;
    for (int k = int'(CH) - 1; k >= 0; k--) begin
      j = (RR != 0) ? int'(ptr) + k : k;
      if (j >= int'(CH)) j = j - int'(CH);
      if (ch_txe[IDX_W'(j)]) win = IDX_W'(j);
    end
    for (int i = 0; i < int'(CH); i++) begin
      if (IDX_W'(i) == win) begin
        sel_re   = ch_re[i];
        sel_we   = ch_we[i];
        sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
        sel_wd   = ch_wd[i*DATA_W +: DATA_W];
      end
      if (IDX_W'(i) == grant) grant_txe = ch_txe[i];
    end
  end

  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
    ptr_next    = (grant == IDX_W'(CH - 1)) ? '0 : grant + 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (ram_txs || timeout_hit) state_next = RELEASE;
      RELEASE: if (!grant_txe) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Registered datapath and handshake outputs. Reset clears everything so an
  // in-flight transaction is dropped without any completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      grant    <= '0;
      cnt      <= '0;
      ch_txs   <= '0;
      ch_err   <= '0;
      ch_out   <= '0;
      ram_txe  <= 1'b0;
      ram_re   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_wd   <= '0;
    end else begin
      ch_txs <= '0;
      ch_err <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= win;
            ram_addr <= sel_addr;
            ram_wd   <= sel_wd;
            ram_we   <= sel_we;
            ram_re   <= sel_re & ~sel_we;  // write wins over read
            ram_txe  <= 1'b1;
            cnt      <= '0;
          end
        end
        BUSY: begin
          // ram_txs takes precedence over a coinciding timeout.
          if (ram_txs) begin
            ram_txe <= 1'b0;
            ch_txs  <= CH'(1) << grant;
            ch_out  <= ram_out;
            ptr     <= ptr_next;
          end else if (timeout_hit) begin
            ram_txe <= 1'b0;
            ch_err  <= CH'(1) << grant;
            ptr     <= ptr_next;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!grant_txe) cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int CH = 3;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam logic [CH*AW-1:0] ADDRS = {64'h3000, 64'h2000, 64'h1000};
  localparam logic [CH*DW-1:0] WDS   = {32'h3, 32'h2, 32'h1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared channel-side stimulus.
  logic [CH-1:0]    ch_re   = '0;
  logic [CH-1:0]    ch_we   = '0;
  logic [CH*AW-1:0] ch_addr = '0;
  logic [CH*DW-1:0] ch_wd   = '0;

  // Directed-mode controls (instance A only) and continuous-request mode.
  logic [CH-1:0] man_txe = '0;
  logic          man_txs = 1'b0;
  logic [DW-1:0] man_out = '0;
  logic          cont    = 1'b0;

  // Instance A: round-robin; instance B: fixed priority.
  logic [CH-1:0] ch_txe_a, ch_txs_a, ch_err_a, ch_txe_b, ch_txs_b, ch_err_b;
  logic [DW-1:0] ch_out_a, ch_out_b, ram_wd_a, ram_wd_b, ram_out_a, ram_out_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic          ram_txe_a, ram_re_a, ram_we_a, ram_txs_a;
  logic          ram_txe_b, ram_re_b, ram_we_b, ram_txs_b;

  // Continuous masters: drop request for one cycle after each pulse.
  logic [CH-1:0] drop_a = '0, drop_b = '0;
  always @(posedge clk) begin
    drop_a <= ch_txs_a | ch_err_a;
    drop_b <= ch_txs_b | ch_err_b;
  end
  assign ch_txe_a = cont ? ~drop_a : man_txe;
  assign ch_txe_b = cont ? ~drop_b : '0;

  // Auto RAM responders for continuous mode: 3-cycle latency.
  logic [3:0] auto_cnt_a = '0, auto_cnt_b = '0;
  logic       auto_txs_a = 1'b0, auto_txs_b = 1'b0;
  always @(posedge clk) begin
    if (!cont || !ram_txe_a || auto_txs_a) begin
      auto_cnt_a <= '0; auto_txs_a <= 1'b0;
    end else if (auto_cnt_a == 4'd2) auto_txs_a <= 1'b1;
    else auto_cnt_a <= auto_cnt_a + 4'd1;
    if (!cont || !ram_txe_b || auto_txs_b) begin
      auto_cnt_b <= '0; auto_txs_b <= 1'b0;
    end else if (auto_cnt_b == 4'd2) auto_txs_b <= 1'b1;
    else auto_cnt_b <= auto_cnt_b + 4'd1;
  end
  assign ram_txs_a = man_txs | auto_txs_a;
  assign ram_out_a = cont ? ram_addr_a[DW-1:0] ^ 32'hA5A5_0000 : man_out;
  assign ram_txs_b = auto_txs_b;
  assign ram_out_b = ram_addr_b[DW-1:0];

  ram_port_arbiter #(.CH(CH), .ADDR_W(AW), .DATA_W(DW), .RR(1), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .ch_txe(ch_txe_a), .ch_re(ch_re), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wd(ch_wd), .ch_txs(ch_txs_a), .ch_err(ch_err_a),
    .ch_out(ch_out_a), .ram_txe(ram_txe_a), .ram_re(ram_re_a), .ram_we(ram_we_a),
    .ram_addr(ram_addr_a), .ram_wd(ram_wd_a), .ram_txs(ram_txs_a), .ram_out(ram_out_a));

  ram_port_arbiter #(.CH(CH), .ADDR_W(AW), .DATA_W(DW), .RR(0), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .ch_txe(ch_txe_b), .ch_re(ch_re), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_wd(ch_wd), .ch_txs(ch_txs_b), .ch_err(ch_err_b),
    .ch_out(ch_out_b), .ram_txe(ram_txe_b), .ram_re(ram_re_b), .ram_we(ram_we_b),
    .ram_addr(ram_addr_b), .ram_wd(ram_wd_b), .ram_txs(ram_txs_b), .ram_out(ram_out_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [CH-1:0]    txe, re, we;
    logic [CH*AW-1:0] addr;
    logic [CH*DW-1:0] wd;
    int               lat;
    logic [DW-1:0]    rdata;
    bit               early;
    logic             exp_re, exp_we;
    logic [AW-1:0]    exp_addr;
    logic [DW-1:0]    exp_wd;
    logic [CH-1:0]    exp_txs;
  } vec_t;

  // One complete transaction on instance A with a hand-driven RAM reply.
  task automatic do_txn(input vec_t v, input string tag);
    @(negedge clk);
    man_txe = v.txe; ch_re = v.re; ch_we = v.we; ch_addr = v.addr; ch_wd = v.wd;
    @(negedge clk);
    check({tag, ".ram_txe"},  ram_txe_a,  1'b1);
    check({tag, ".ram_re"},   ram_re_a,   v.exp_re);
    check({tag, ".ram_we"},   ram_we_a,   v.exp_we);
    check({tag, ".ram_addr"}, ram_addr_a, v.exp_addr);
    check({tag, ".ram_wd"},   ram_wd_a,   v.exp_wd);
    if (v.early) man_txe = '0;
    repeat (v.lat - 1) @(negedge clk);
    man_txs = 1'b1; man_out = v.rdata;
    @(negedge clk);
    man_txs = 1'b0;
    check({tag, ".ch_txs"},   ch_txs_a,  v.exp_txs);
    check({tag, ".ch_err"},   ch_err_a,  '0);
    check({tag, ".ch_out"},   ch_out_a,  v.rdata);
    check({tag, ".txe_low"},  ram_txe_a, 1'b0);
    man_txe = '0;
    @(negedge clk);
    check({tag, ".txs_1cyc"}, ch_txs_a,  '0);
    @(negedge clk);
  endtask

  logic [CH-1:0] log_a[$];
  logic [CH-1:0] log_b[$];
  always @(negedge clk) begin
    if (cont && ch_txs_a != '0) log_a.push_back(ch_txs_a);
    if (cont && ch_txs_b != '0) log_b.push_back(ch_txs_b);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   n;

    vecs[0] = '{txe:3'b001, re:3'b001, we:3'b000, addr:{64'h0, 64'h0, 64'h10}, wd:'0,
                lat:3, rdata:32'hDEAD_BEEF, early:0,
                exp_re:1, exp_we:0, exp_addr:64'h10, exp_wd:32'h0, exp_txs:3'b001};
    vecs[1] = '{txe:3'b010, re:3'b010, we:3'b010, addr:{64'h0, 64'h20, 64'h0},
                wd:{32'h0, 32'h1234_5678, 32'h0}, lat:3, rdata:32'h0000_00AA, early:0,
                exp_re:0, exp_we:1, exp_addr:64'h20, exp_wd:32'h1234_5678, exp_txs:3'b010};
    // ptr=2: scan 2,0 -> channel 0
    vecs[2] = '{txe:3'b011, re:3'b011, we:3'b000, addr:ADDRS, wd:WDS,
                lat:1, rdata:32'h1111_1111, early:0,
                exp_re:1, exp_we:0, exp_addr:64'h1000, exp_wd:32'h1, exp_txs:3'b001};
    // ptr=1 -> channel 1
    vecs[3] = '{txe:3'b111, re:3'b010, we:3'b100, addr:ADDRS, wd:WDS,
                lat:2, rdata:32'h2222_2222, early:0,
                exp_re:1, exp_we:0, exp_addr:64'h2000, exp_wd:32'h2, exp_txs:3'b010};
    // ptr=2 -> channel 2 (write)
    vecs[4] = '{txe:3'b101, re:3'b001, we:3'b100, addr:ADDRS, wd:WDS,
                lat:4, rdata:32'h3333_3333, early:0,
                exp_re:0, exp_we:1, exp_addr:64'h3000, exp_wd:32'h3, exp_txs:3'b100};
    // ptr=0: bit 0 clear -> channel 1
    vecs[5] = '{txe:3'b110, re:3'b110, we:3'b000, addr:ADDRS, wd:WDS,
                lat:1, rdata:32'h4444_4444, early:0,
                exp_re:1, exp_we:0, exp_addr:64'h2000, exp_wd:32'h2, exp_txs:3'b010};
    // ptr=2, request dropped during BUSY -> ch_txs still pulses
    vecs[6] = '{txe:3'b100, re:3'b100, we:3'b000, addr:ADDRS, wd:WDS,
                lat:3, rdata:32'h5555_5555, early:1,
                exp_re:1, exp_we:0, exp_addr:64'h3000, exp_wd:32'h3, exp_txs:3'b100};

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.ram_txe",  ram_txe_a,  1'b0);
    check("rst.ch_txs",   ch_txs_a,   '0);
    check("rst.ch_err",   ch_err_a,   '0);
    check("rst.ch_out",   ch_out_a,   '0);
    check("rst.ram_addr", ram_addr_a, '0);

    for (int i = 0; i < 7; i++) do_txn(vecs[i], $sformatf("v%0d", i));

    // Timeout: RAM silent, ptr=0 -> channel 0.
    @(negedge clk);
    man_txe = 3'b001; ch_re = 3'b001; ch_we = '0;
    @(negedge clk);
    n = 0;
    while (ram_txe_a && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("to.busy_cycles", n,          8);
    check("to.ch_err",      ch_err_a,   3'b001);
    check("to.ch_txs",      ch_txs_a,   '0);
    check("to.ch_out",      ch_out_a,   32'h5555_5555);
    check("to.ram_txe",     ram_txe_a,  1'b0);
    man_txe = '0;
    @(negedge clk);
    check("to.err_1cyc",    ch_err_a,   '0);
    @(negedge clk);
    // Normal 3-cycle completion after the timeout; ptr=1 -> channel 0.
    v = '{txe:3'b001, re:3'b001, we:3'b000, addr:ADDRS, wd:WDS,
          lat:3, rdata:32'h6666_6666, early:0,
          exp_re:1, exp_we:0, exp_addr:64'h1000, exp_wd:32'h1, exp_txs:3'b001};
    do_txn(v, "to_next");

    // Async reset mid-BUSY; ptr=1 -> channel 2 granted first.
    @(negedge clk);
    man_txe = 3'b100; ch_re = 3'b100; ch_we = '0;
    @(negedge clk);
    check("ar.granted", ram_txe_a, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("ar.ram_txe", ram_txe_a, 1'b0);
    check("ar.ch_txs",  ch_txs_a,  '0);
    check("ar.ch_err",  ch_err_a,  '0);
    check("ar.ch_out",  ch_out_a,  '0);
    man_txe = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Stray ram_txs while idle.
    man_txs = 1'b1; man_out = 32'hFFFF_FFFF;
    @(negedge clk);
    man_txs = 1'b0;
    check("stray.ch_txs",  ch_txs_a,  '0);
    check("stray.ch_err",  ch_err_a,  '0);
    check("stray.ch_out",  ch_out_a,  '0);
    check("stray.ram_txe", ram_txe_a, 1'b0);
    // First grant after reset goes to channel 0.
    v = '{txe:3'b111, re:3'b111, we:3'b000, addr:ADDRS, wd:WDS,
          lat:2, rdata:32'h7777_7777, early:0,
          exp_re:1, exp_we:0, exp_addr:64'h1000, exp_wd:32'h1, exp_txs:3'b001};
    do_txn(v, "ar_first");
    // ptr=1 -> channel 2, leaving ptr=0.
    v = '{txe:3'b100, re:3'b100, we:3'b000, addr:ADDRS, wd:WDS,
          lat:2, rdata:32'h8888_8888, early:0,
          exp_re:1, exp_we:0, exp_addr:64'h3000, exp_wd:32'h3, exp_txs:3'b100};
    do_txn(v, "ar_second");

    // All channels requesting continuously.
    ch_re = '1; ch_we = '0; ch_addr = ADDRS; ch_wd = WDS;
    cont = 1'b1;
    n = 0;
    while ((log_a.size() < 6 || log_b.size() < 6) && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("rr.completed", (log_a.size() >= 6 && log_b.size() >= 6), 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k < log_a.size())
        check($sformatf("rr.a%0d", k), log_a[k], 3'b001 << (k % 3));
      if (k < log_b.size())
        check($sformatf("fp.b%0d", k), log_b[k], 3'b001);
    end
    cont = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
